// File: rtl/layer_sequencer.sv
// layer_sequencer: sequences one conv layer as output-channel passes of DMA + compute handshakes.
// Ports: start/ack/done/busy talk to the config block; IC_Num..output_start_address are the
// layer config (latched on ack); cmd_* with dma_done drive the memory mover; pass_* drive the
// compute array.
module layer_sequencer #(
  parameter int OC_PER_PASS = 8,
  parameter int IC_W = 10,
  parameter int OC_W = 10,
  parameter int FS_W = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  output logic            ack,
  output logic            done,
  output logic            busy,
  input  logic [IC_W-1:0] IC_Num,
  input  logic [OC_W-1:0] OC_Num,
  input  logic [FS_W-1:0] RC_Size,
  input  logic [FS_W-1:0] ORC_Size,
  input  logic            load_input,
  input  logic            store_output,
  input  logic [31:0]     bias_start_address,
  input  logic [31:0]     input_start_address,
  input  logic [31:0]     output_start_address,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic [1:0]      cmd_type,
  output logic [31:0]     cmd_addr,
  output logic [31:0]     cmd_len,
  input  logic            dma_done,
  output logic            pass_start,
  output logic [OC_W-1:0] pass_oc_base,
  output logic [6:0]      pass_oc_count,
  input  logic            pass_done
);
  typedef enum logic [3:0] {
    IDLE, LOAD_IN, WAIT_IN, BIAS, WAIT_BIAS, COMPUTE, STORE, WAIT_STORE, NEXT, FINISH
  } state_t;
  localparam logic [OC_W:0] PASS = (OC_W+1)'(OC_PER_PASS);
  state_t state, state_n;
  logic [IC_W-1:0] ic_q;
  logic [OC_W-1:0] oc_q, oc_base, rem;
  logic [FS_W-1:0] rc_q, orc_q;
  logic            load_q, store_q, ack_q, pass_start_q;
  logic [31:0]     bias_q, in_q, out_q, in_len, orc_sq, st_len;
  logic [6:0]      cnt;
  logic [OC_W:0]   next_base;
  assign rem       = oc_q - oc_base;
  assign cnt       = ({1'b0, rem} > PASS) ? 7'(OC_PER_PASS) : 7'(rem);
  assign next_base = {1'b0, oc_base} + (OC_W+1)'(cnt);
  assign in_len    = 32'(ic_q) * 32'(rc_q) * 32'(rc_q);
  assign orc_sq    = 32'(orc_q) * 32'(orc_q);
  assign st_len    = 32'(cnt) * orc_sq;
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (start) state_n = load_input ? LOAD_IN : BIAS;
      LOAD_IN:    if (in_len == 0) state_n = BIAS;
                  else if (cmd_ready) state_n = WAIT_IN;
      WAIT_IN:    if (dma_done) state_n = BIAS;
      BIAS:       if (oc_q == 0) state_n = FINISH;
                  else if (cmd_ready) state_n = WAIT_BIAS;
      WAIT_BIAS:  if (dma_done) state_n = COMPUTE;
      // a pass_done coincident with our own pass_start cannot belong to this pass
      COMPUTE:    if (pass_done && !pass_start_q) state_n = store_q ? STORE : NEXT;
      STORE:      if (st_len == 0) state_n = NEXT;
                  else if (cmd_ready) state_n = WAIT_STORE;
      WAIT_STORE: if (dma_done) state_n = NEXT;
      NEXT:       state_n = (next_base >= {1'b0, oc_q}) ? FINISH : BIAS;
      FINISH:     state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      {ic_q, oc_q, rc_q, orc_q, load_q, store_q} <= '0;
      {bias_q, in_q, out_q} <= '0;
      oc_base <= '0;
      ack_q <= 1'b0;
      pass_start_q <= 1'b0;
    end else begin
      ack_q <= state == IDLE && start;
      pass_start_q <= state == WAIT_BIAS && dma_done;
      if (state == IDLE && start) begin
        {ic_q, oc_q, rc_q, orc_q} <= {IC_Num, OC_Num, RC_Size, ORC_Size};
        {load_q, store_q} <= {load_input, store_output};
        {bias_q, in_q, out_q} <= {bias_start_address, input_start_address, output_start_address};
        oc_base <= '0;
      end
      if (state == NEXT) oc_base <= next_base[OC_W-1:0];
    end
  assign ack           = ack_q;
  assign done          = state == FINISH;
  assign busy          = state != IDLE;
  assign pass_start    = pass_start_q;
  assign pass_oc_base  = state == COMPUTE ? oc_base : '0;
  assign pass_oc_count = state == COMPUTE ? cnt : '0;
  assign cmd_valid     = (state == LOAD_IN && in_len != 0) || (state == BIAS && oc_q != 0) ||
                         (state == STORE && st_len != 0);
  assign cmd_type      = state == STORE ? 2'd2 : state == BIAS ? 2'd1 : 2'd0;
  assign cmd_addr      = state == LOAD_IN ? in_q :
                         state == BIAS    ? bias_q + (32'(oc_base) << 2) :
                         state == STORE   ? out_q + 32'(oc_base) * orc_sq : '0;
  assign cmd_len       = state == LOAD_IN ? in_len :
                         state == BIAS    ? 32'(cnt) << 2 :
                         state == STORE   ? st_len : '0;
  // load_q is only needed for the IDLE decision, taken from the live input
  logic unused_ok;
  assign unused_ok = load_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: randomized bench for layer_sequencer against a per-layer command/pass model.
module tb_layer_sequencer;
  localparam int P = 8;
  logic clock = 0, reset = 0, start = 0;
  logic ack, done, busy, cmd_valid, dma_done = 0, pass_start, pass_done = 0, cmd_ready = 0;
  logic [9:0] IC_Num = 0, OC_Num = 0, pass_oc_base;
  logic [7:0] RC_Size = 0, ORC_Size = 0;
  logic load_input = 0, store_output = 0;
  logic [31:0] bias_start_address = 0, input_start_address = 0, output_start_address = 0;
  logic [1:0] cmd_type;
  logic [31:0] cmd_addr, cmd_len;
  logic [6:0] pass_oc_count;
  logic [87:0] outs;
  assign outs = {ack, done, busy, cmd_valid, cmd_type, cmd_addr, cmd_len, pass_start,
                 pass_oc_base, pass_oc_count};
  layer_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .ack(ack), .done(done), .busy(busy),
    .IC_Num(IC_Num), .OC_Num(OC_Num), .RC_Size(RC_Size), .ORC_Size(ORC_Size),
    .load_input(load_input), .store_output(store_output),
    .bias_start_address(bias_start_address), .input_start_address(input_start_address),
    .output_start_address(output_start_address), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .dma_done(dma_done),
    .pass_start(pass_start), .pass_oc_base(pass_oc_base), .pass_oc_count(pass_oc_count),
    .pass_done(pass_done)
  );
  always #5 clock = ~clock;
  int vectors = 0, errors = 0;
  logic [65:0] exp_cmd[$];
  logic [16:0] exp_pass[$];
  int n_cmd = 0, n_pass = 0, acks = 0, dones = 0, cyc = 0, last_ack = 0, last_done = -1000, gap = 0;
  int pend = 0, ppend = 0, force_stall = 0;
  bit always_ready = 0;
  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clock);
    #1;
  endtask
  // expected traffic of one layer, straight from the pass/command rules
  task automatic build_exp();
    longint b, c, len;
    exp_cmd.delete();
    exp_pass.delete();
    n_cmd = 0;
    n_pass = 0;
    len = longint'(IC_Num) * RC_Size * RC_Size;
    if (load_input && len != 0) exp_cmd.push_back({2'd0, input_start_address, 32'(len)});
    for (b = 0; b < OC_Num; b += c) begin
      c = (OC_Num - b < P) ? OC_Num - b : P;
      exp_cmd.push_back({2'd1, 32'(bias_start_address + 4 * b), 32'(4 * c)});
      exp_pass.push_back({10'(b), 7'(c)});
      len = c * ORC_Size * ORC_Size;
      if (store_output && len != 0)
        exp_cmd.push_back({2'd2, 32'(output_start_address + b * ORC_Size * ORC_Size), 32'(len)});
    end
  endtask
  task automatic set_cfg(input int ic, oc, rc, orc, input bit ld, st,
                         input logic [31:0] ba, ia, oa);
    IC_Num = 10'(ic); OC_Num = 10'(oc); RC_Size = 8'(rc); ORC_Size = 8'(orc);
    load_input = ld; store_output = st;
    bias_start_address = ba; input_start_address = ia; output_start_address = oa;
  endtask
  task automatic rand_cfg(input bit junk);
    set_cfg($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 1023),
            junk ? $urandom_range(0, 1023) : $urandom_range(0, 40),
            $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 255),
            $urandom_range(0, 5) == 0 ? 0 : $urandom_range(1, 255),
            1'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
  endtask
  task automatic launch();
    int t = 0;
    build_exp();
    acks = 0;
    dones = 0;
    start = 1;
    while (acks == 0 && t < 20) begin tick(); t++; end
    check("ack_seen", acks, 1);
    check("busy_ack", busy, 1);
    gap = last_ack - last_done;
  endtask
  task automatic run_layer(input bit keep);
    int t = 0;
    launch();
    if (!keep) begin
      start = 0;
      rand_cfg(1);
    end
    while (dones == 0 && t < 3000) begin tick(); t++; end
    check("done_seen", dones, 1);
    check("busy_done", busy, 1);
    check("ack_once", acks, 1);
    tick();
    check("busy_off", busy, 0);
    check("n_cmd", n_cmd, exp_cmd.size());
    check("n_pass", n_pass, exp_pass.size());
  endtask
  // memory mover and compute array responders; also checks every offered command/pass
  initial begin
    bit acc;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        pend = 0; ppend = 0; dma_done = 0; pass_done = 0; cmd_ready = 0;
      end else begin
        acks += 32'(ack);
        dones += 32'(done);
        if (ack) last_ack = cyc;
        if (done) last_done = cyc;
        dma_done = 0;
        acc = 0;
        if (pend > 0) begin
          check("one_outstanding", cmd_valid, 0);
          pend--;
          if (pend == 0) dma_done = 1;
          cmd_ready = always_ready || 1'($urandom);
        end else begin
          if (cmd_valid)
            check("cmd", {cmd_type, cmd_addr, cmd_len}, n_cmd < exp_cmd.size() ? exp_cmd[n_cmd] : 'x);
          if (force_stall > 0 && cmd_valid) begin
            cmd_ready = 0;
            force_stall--;
            if (force_stall == 2) dma_done = 1;
          end else begin
            cmd_ready = always_ready || ($urandom_range(0, 2) != 0);
            acc = cmd_valid && cmd_ready;
            if (acc) begin
              n_cmd++;
              pend = $urandom_range(1, 4);
            end else if ($urandom_range(0, 5) == 0) dma_done = 1;
          end
        end
        pass_done = 0;
        if (ppend > 0) begin
          if (n_pass <= exp_pass.size())
            check("pass_hold", {pass_start, pass_oc_base, pass_oc_count}, {1'b0, exp_pass[n_pass-1]});
          ppend--;
          if (ppend == 0) pass_done = 1;
        end else if (pass_start) begin
          check("pass", {pass_oc_base, pass_oc_count}, n_pass < exp_pass.size() ? exp_pass[n_pass] : 'x);
          n_pass++;
          ppend = $urandom_range(1, 5);
        end else if ($urandom_range(0, 7) == 0) pass_done = 1;
      end
    end
  end
  initial begin
    int t;
    repeat (3) tick();
    check("rst_init", outs, 0);
    reset = 1;
    tick();
    always_ready = 1;
    set_cfg(3, 16, 8, 6, 1, 1, 32'h1000, 32'h2000, 32'h3000);
    run_layer(0);
    set_cfg(3, 10, 8, 6, 1, 1, 32'h1000, 32'h2000, 32'h3000);
    run_layer(0);
    set_cfg(3, 4, 8, 6, 0, 0, 32'h1000, 32'h2000, 32'h3000);
    run_layer(0);
    set_cfg(3, 0, 8, 6, 1, 1, 32'h1000, 32'h2000, 32'h3000);
    run_layer(0);
    always_ready = 0;
    force_stall = 5;
    set_cfg(5, 12, 7, 3, 1, 1, 32'hffff_fff0, 32'h40, 32'hffff_ff00);
    run_layer(0);
    check("stall_used", force_stall, 0);
    set_cfg(3, 16, 8, 6, 1, 1, 32'h1000, 32'h2000, 32'h3000);
    launch();
    start = 0;
    t = 0;
    while (!(n_cmd == 2 && pend > 0) && t < 300) begin tick(); t++; end
    @(posedge clock);
    #2;
    check("busy_pre_rst", busy, 1);
    reset = 0;
    #1;
    check("rst_mid", outs, 0);
    tick();
    tick();
    reset = 1;
    set_cfg(3, 16, 8, 6, 1, 1, 32'h1000, 32'h2000, 32'h3000);
    run_layer(0);
    set_cfg(2, 9, 4, 4, 1, 1, 32'h500, 32'h600, 32'h700);
    run_layer(1);
    run_layer(0);
    check("ack_gap_ok", gap >= 2, 1);
    repeat (30) begin
      rand_cfg(0);
      run_layer(0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
